ac97_cmd_sched: RTL and testbench

Command-slot scheduler for the AC97 link. It shares the codec register channel (output slots 1/2) between NREQ requesters, such as the init sequence, volume/rotary control and status polling. Round-robin arbitration happens once per frame. For reads, it matches codec responses in input slots 1/2 back to the issuing requester, with a timeout. It sits between the requesters and the serial link framer, in place of a fixed configuration ROM sequencer.

---
 rtl/ac97_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/ac97_cmd_sched.sv | 160 ++++++++++++++++
 tb/tb_ac97_cmd_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac97_pkg.sv
// Shared AC97 link definitions: slot geometry, field positions and the
// command scheduler state encoding.
package ac97_pkg;

    localparam int SLOT_W = 20;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;

    // Output/input slot 1: read/write flag and register address.
    localparam int SLOT1_RW_BIT  = 19;
    localparam int SLOT1_ADDR_HI = 18;
    localparam int SLOT1_ADDR_LO = 12;

    // Output/input slot 2: register data, left-justified.
    localparam int SLOT2_DATA_HI = 19;
    localparam int SLOT2_DATA_LO = 4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WAIT_RD = 1'b1
    } sched_state_e;

    // Command address slot: {rw, addr, 12'h000}.
    function automatic logic [SLOT_W-1:0] make_slot1(input logic rw,
                                                     input logic [ADDR_W-1:0] addr);
        return {rw, addr, 12'h000};
    endfunction

    // Command data slot: {data, 4'h0}.
    function automatic logic [SLOT_W-1:0] make_slot2(input logic [DATA_W-1:0] data);
        return {data, 4'h0};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, starting the search at
// a registered priority pointer that moves past the winner on advance.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N);
    localparam int CW    = IDX_W + 1;

    logic [IDX_W-1:0] ptr;
    logic [CW-1:0]    cand;
    logic             found;

    // Search requesters in order ptr, ptr+1, ... (mod N); first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
        grant[grant_idx] = found;
    end

    // Priority pointer moves to the requester after the winner, only on a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/ac97_cmd_sched.sv
// AC97 command-slot scheduler: one register command per frame, round-robin
// between requesters, with read responses routed back to the issuer.
//
// Request handshake: a requester raises req_valid[i] with req_rw/addr/data
// stable and holds them; the scheduler samples only at ac97_strobe, and the
// transfer completes on the single-cycle req_ready[i] pulse that follows.
// Dropping req_valid before the grant withdraws the request.
module ac97_cmd_sched
    import ac97_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                     ac97_bitclk,
    input  logic                     reset,
    input  logic                     ac97_strobe,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_rw,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_timeout,
    output logic [SLOT_W-1:0]        ac97_out_slot1,
    output logic                     ac97_out_slot1_valid,
    output logic [SLOT_W-1:0]        ac97_out_slot2,
    output logic                     ac97_out_slot2_valid,
    input  logic                     ac97_in_slot1_valid,
    input  logic [SLOT_W-1:0]        ac97_in_slot1,
    input  logic [SLOT_W-1:0]        ac97_in_slot2
);

    localparam int IDX_W = $clog2(NREQ);

    sched_state_e      state, state_nxt;
    logic [3:0]        tmo_cnt, tmo_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [IDX_W-1:0]  owner_q, owner_nxt;

    logic [NREQ-1:0]   ready_nxt, rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_data_nxt;
    logic              rsp_tmo_nxt;
    logic [SLOT_W-1:0] slot1_nxt, slot2_nxt;
    logic              slot1_v_nxt, slot2_v_nxt;

    logic [NREQ-1:0]   grant;
    logic [IDX_W-1:0]  g;
    logic              rd_match;
    logic              unused_slot_bits;

    // Echo fields the scheduler does not look at.
    assign unused_slot_bits = ^{ac97_in_slot1[SLOT1_RW_BIT], ac97_in_slot1[SLOT1_ADDR_LO-1:0],
                                ac97_in_slot2[SLOT2_DATA_LO-1:0]};

    assign rd_match = ac97_in_slot1_valid &&
                      (ac97_in_slot1[SLOT1_ADDR_HI:SLOT1_ADDR_LO] == addr_q);

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk       (ac97_bitclk),
        .reset     (reset),
        .req       (req_valid),
        .advance   (ac97_strobe && (state == IDLE)),
        .grant     (grant),
        .grant_idx (g)
    );

    // Next-state and next-output decisions; everything changes only at strobe.
    always_comb begin
        state_nxt     = state;
        tmo_nxt       = tmo_cnt;
        addr_nxt      = addr_q;
        owner_nxt     = owner_q;
        ready_nxt     = '0;
        rsp_valid_nxt = '0;
        rsp_data_nxt  = rsp_data;
        rsp_tmo_nxt   = rsp_timeout;
        slot1_nxt     = ac97_out_slot1;
        slot1_v_nxt   = ac97_out_slot1_valid;
        slot2_nxt     = ac97_out_slot2;
        slot2_v_nxt   = ac97_out_slot2_valid;
        if (ac97_strobe) begin
            // Any frame without a fresh command carries empty, invalid slots.
            slot1_nxt   = '0;
            slot1_v_nxt = 1'b0;
            slot2_nxt   = '0;
            slot2_v_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        ready_nxt   = grant;
                        slot1_nxt   = make_slot1(req_rw[g], req_addr[ADDR_W*g +: ADDR_W]);
                        slot1_v_nxt = 1'b1;
                        slot2_v_nxt = 1'b1;
                        if (req_rw[g]) begin
                            slot2_nxt = '0;
                            addr_nxt  = req_addr[ADDR_W*g +: ADDR_W];
                            owner_nxt = g;
                            tmo_nxt   = '0;
                            state_nxt = WAIT_RD;
                        end else begin
                            slot2_nxt = make_slot2(req_data[DATA_W*g +: DATA_W]);
                        end
                    end
                end
                WAIT_RD: begin
                    if (tmo_cnt == 4'd0) begin
                        // Input slots still describe the issue frame here.
                        tmo_nxt = 4'd1;
                    end else if (rd_match) begin
                        rsp_valid_nxt[owner_q] = 1'b1;
                        rsp_data_nxt  = ac97_in_slot2[SLOT2_DATA_HI:SLOT2_DATA_LO];
                        rsp_tmo_nxt   = 1'b0;
                        state_nxt     = IDLE;
                    end else if (tmo_cnt == 4'(RD_TIMEOUT - 1)) begin
                        rsp_valid_nxt[owner_q] = 1'b1;
                        rsp_data_nxt  = '0;
                        rsp_tmo_nxt   = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        tmo_nxt = tmo_cnt + 4'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and registered outputs; reset takes precedence over strobe.
    always_ff @(posedge ac97_bitclk) begin
        if (reset) begin
            state                <= IDLE;
            tmo_cnt              <= '0;
            addr_q               <= '0;
            owner_q              <= '0;
            req_ready            <= '0;
            rsp_valid            <= '0;
            rsp_data             <= '0;
            rsp_timeout          <= 1'b0;
            ac97_out_slot1       <= '0;
            ac97_out_slot1_valid <= 1'b0;
            ac97_out_slot2       <= '0;
            ac97_out_slot2_valid <= 1'b0;
        end else begin
            state                <= state_nxt;
            tmo_cnt              <= tmo_nxt;
            addr_q               <= addr_nxt;
            owner_q              <= owner_nxt;
            req_ready            <= ready_nxt;
            rsp_valid            <= rsp_valid_nxt;
            rsp_data             <= rsp_data_nxt;
            rsp_timeout          <= rsp_tmo_nxt;
            ac97_out_slot1       <= slot1_nxt;
            ac97_out_slot1_valid <= slot1_v_nxt;
            ac97_out_slot2       <= slot2_nxt;
            ac97_out_slot2_valid <= slot2_v_nxt;
        end
    end

endmodule

// File: tb/tb_ac97_cmd_sched.sv
// Bench for ac97_cmd_sched: frame-level model compared every cycle, a grant
// order scoreboard, and literal checks from the directed scenarios.
module tb_ac97_cmd_sched;

    localparam int NREQ       = 3;
    localparam int RD_TIMEOUT = 4;
    localparam int FRAME      = 256;

    logic                 ac97_bitclk;
    logic                 reset;
    logic                 ac97_strobe;
    logic [NREQ-1:0]      req_valid, req_rw;
    logic [NREQ*7-1:0]    req_addr;
    logic [NREQ*16-1:0]   req_data;
    logic [NREQ-1:0]      req_ready, rsp_valid;
    logic [15:0]          rsp_data;
    logic                 rsp_timeout;
    logic [19:0]          ac97_out_slot1, ac97_out_slot2;
    logic                 ac97_out_slot1_valid, ac97_out_slot2_valid;
    logic                 ac97_in_slot1_valid;
    logic [19:0]          ac97_in_slot1, ac97_in_slot2;

    int tests;
    int fails;
    logic [7:0] exp_q[$];

    ac97_cmd_sched #(.NREQ(NREQ), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .ac97_bitclk          (ac97_bitclk),
        .reset                (reset),
        .ac97_strobe          (ac97_strobe),
        .req_valid            (req_valid),
        .req_rw               (req_rw),
        .req_addr             (req_addr),
        .req_data             (req_data),
        .req_ready            (req_ready),
        .rsp_valid            (rsp_valid),
        .rsp_data             (rsp_data),
        .rsp_timeout          (rsp_timeout),
        .ac97_out_slot1       (ac97_out_slot1),
        .ac97_out_slot1_valid (ac97_out_slot1_valid),
        .ac97_out_slot2       (ac97_out_slot2),
        .ac97_out_slot2_valid (ac97_out_slot2_valid),
        .ac97_in_slot1_valid  (ac97_in_slot1_valid),
        .ac97_in_slot1        (ac97_in_slot1),
        .ac97_in_slot2        (ac97_in_slot2)
    );

    // ---------------- clock / frame strobe ----------------
    initial begin
        ac97_bitclk = 1'b0;
        forever #5 ac97_bitclk = ~ac97_bitclk;
    end

    int phase;
    initial begin
        ac97_strobe = 1'b0;
        phase = 0;
        forever begin
            @(posedge ac97_bitclk);
            #1;
            phase = (phase + 1) % FRAME;
            ac97_strobe = (phase == FRAME - 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] pack(input logic [NREQ-1:0] rdy, input logic [NREQ-1:0] rv,
                                         input logic [15:0] rd, input logic rt,
                                         input logic [19:0] s1, input logic s1v,
                                         input logic [19:0] s2, input logic s2v);
        return {31'd0, rdy, rv, rd, rt, s1, s1v, s2, s2v};
    endfunction

    // ---------------- behavioural model ----------------
    // Frame-level view: at each strobe either issue one command (round robin
    // after the last winner) or, with a read outstanding, count strobes since
    // issue and answer on a matching echo (from the 2nd strobe) or at timeout.
    logic [NREQ-1:0] e_ready, e_rsp_valid;
    logic [15:0]     e_rsp_data;
    logic            e_tmo;
    logic [19:0]     e_s1, e_s2;
    logic            e_s1v, e_s2v;
    bit              m_pend;
    int              m_n, m_owner, m_last;
    logic [6:0]      m_addr;

    initial begin
        e_ready = '0; e_rsp_valid = '0; e_rsp_data = '0; e_tmo = 1'b0;
        e_s1 = '0; e_s2 = '0; e_s1v = 1'b0; e_s2v = 1'b0;
        m_pend = 0; m_n = 0; m_owner = 0; m_last = NREQ - 1; m_addr = '0;
        forever begin
            @(posedge ac97_bitclk);
            e_ready = '0;
            e_rsp_valid = '0;
            if (reset) begin
                e_rsp_data = '0; e_tmo = 1'b0;
                e_s1 = '0; e_s2 = '0; e_s1v = 1'b0; e_s2v = 1'b0;
                m_pend = 0; m_n = 0; m_owner = 0; m_last = NREQ - 1; m_addr = '0;
            end else if (ac97_strobe) begin
                e_s1 = '0; e_s2 = '0; e_s1v = 1'b0; e_s2v = 1'b0;
                if (m_pend) begin
                    m_n++;
                    if (m_n >= 2 && ac97_in_slot1_valid && ac97_in_slot1[18:12] == m_addr) begin
                        e_rsp_valid[m_owner] = 1'b1;
                        e_rsp_data = ac97_in_slot2[19:4];
                        e_tmo = 1'b0;
                        m_pend = 0;
                    end else if (m_n == RD_TIMEOUT) begin
                        e_rsp_valid[m_owner] = 1'b1;
                        e_rsp_data = '0;
                        e_tmo = 1'b1;
                        m_pend = 0;
                    end
                end else begin
                    int gsel;
                    gsel = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        int c;
                        c = (m_last + k) % NREQ;
                        if (gsel < 0 && req_valid[c]) gsel = c;
                    end
                    if (gsel >= 0) begin
                        e_ready[gsel] = 1'b1;
                        e_s1  = {req_rw[gsel], req_addr[gsel*7 +: 7], 12'h000};
                        e_s1v = 1'b1;
                        e_s2v = 1'b1;
                        if (req_rw[gsel]) begin
                            e_s2 = '0;
                            m_pend = 1; m_n = 0; m_owner = gsel;
                            m_addr = req_addr[gsel*7 +: 7];
                        end else begin
                            e_s2 = {req_data[gsel*16 +: 16], 4'h0};
                        end
                        m_last = gsel;
                    end
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge ac97_bitclk);
            check("cycle_outputs",
                  pack(req_ready, rsp_valid, rsp_data, rsp_timeout,
                       ac97_out_slot1, ac97_out_slot1_valid, ac97_out_slot2, ac97_out_slot2_valid),
                  pack(e_ready, e_rsp_valid, e_rsp_data, e_tmo, e_s1, e_s1v, e_s2, e_s2v));
        end
    end

    // Grant scoreboard: each observed grant must be the next expected index.
    initial begin
        forever begin
            @(negedge ac97_bitclk);
            if (req_ready !== '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 96'(req_ready), 96'd0);
                end else begin
                    logic [7:0] gi;
                    logic [NREQ-1:0] oh;
                    gi = exp_q.pop_front();
                    oh = '0;
                    oh[gi] = 1'b1;
                    check("grant_order", 96'(req_ready), 96'(oh));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_strobe();
        int n;
        n = 0;
        forever begin
            @(posedge ac97_bitclk);
            n++;
            if (ac97_strobe === 1'b1) break;
            if (n > FRAME + 8) begin
                tests++;
                fails++;
                $display("FAIL strobe_wait: no strobe within %0d cycles", n);
                break;
            end
        end
        #2;
    endtask

    task automatic set_req(input int i, input logic v, input logic rw,
                           input logic [6:0] a, input logic [15:0] d);
        req_valid[i]        = v;
        req_rw[i]           = rw;
        req_addr[i*7 +: 7]  = a;
        req_data[i*16 +: 16] = d;
    endtask

    task automatic set_codec(input logic v, input logic [19:0] s1, input logic [19:0] s2);
        ac97_in_slot1_valid = v;
        ac97_in_slot1       = s1;
        ac97_in_slot2       = s2;
    endtask

    // ---------------- directed scenarios ----------------
    logic [2:0] rr_tbl [6];

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0;
        set_codec(1'b0, 20'h0, 20'h0);
        rr_tbl = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

        repeat (4) @(posedge ac97_bitclk);
        #1;
        check("reset_outputs",
              pack(req_ready, rsp_valid, rsp_data, rsp_timeout,
                   ac97_out_slot1, ac97_out_slot1_valid, ac97_out_slot2, ac97_out_slot2_valid),
              96'd0);
        reset = 1'b0;

        // Single write from requester 0.
        set_req(0, 1'b1, 1'b0, 7'h02, 16'h0808);
        exp_q.push_back(8'd0);
        wait_strobe();
        check("wr_slot1", 96'(ac97_out_slot1), 96'h02000);
        check("wr_slot2", 96'(ac97_out_slot2), 96'h08080);
        check("wr_valids", 96'({ac97_out_slot1_valid, ac97_out_slot2_valid}), 96'h3);
        check("wr_ready", 96'(req_ready), 96'h1);
        req_valid[0] = 1'b0;
        @(posedge ac97_bitclk);
        #1;
        check("wr_ready_pulse", 96'(req_ready), 96'h0);
        wait_strobe();
        check("wr_idle_valids", 96'({ac97_out_slot1_valid, ac97_out_slot2_valid}), 96'h0);

        // All three write continuously; pointer sits after requester 0.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 7'(7'h10 + i), 16'(16'hA000 + i));
        foreach (rr_tbl[k]) exp_q.push_back(8'($clog2(int'(rr_tbl[k]))));
        for (int k = 0; k < 6; k++) begin
            wait_strobe();
            check("rr_grant", 96'(req_ready), 96'(rr_tbl[k]));
            if (k == 0) begin
                check("rr_slot1", 96'(ac97_out_slot1), 96'h11000);
                check("rr_slot2", 96'(ac97_out_slot2), 96'hA0010);
            end
        end
        req_valid = '0;

        // Read hit for requester 1; echo is present from the issue frame on.
        set_req(1, 1'b1, 1'b1, 7'h26, 16'h0);
        exp_q.push_back(8'd1);
        wait_strobe();
        check("rd_slot1", 96'(ac97_out_slot1), 96'hA6000);
        check("rd_slot2", 96'(ac97_out_slot2), 96'h0);
        check("rd_ready", 96'(req_ready), 96'h2);
        req_valid[1] = 1'b0;
        set_codec(1'b1, 20'h26000, 20'h000F0);
        wait_strobe();
        check("rd_first_strobe_ignored", 96'(rsp_valid), 96'h0);
        wait_strobe();
        check("rd_rsp_valid", 96'(rsp_valid), 96'h2);
        check("rd_rsp_data", 96'(rsp_data), 96'h000F);
        check("rd_rsp_timeout", 96'(rsp_timeout), 96'h0);
        set_codec(1'b0, 20'h0, 20'h0);

        // Read timeout on wrong echoes; requester 0 write waits meanwhile.
        set_req(2, 1'b1, 1'b1, 7'h7C, 16'h0);
        set_req(0, 1'b1, 1'b0, 7'h05, 16'h1234);
        exp_q.push_back(8'd2);
        exp_q.push_back(8'd0);
        set_codec(1'b1, 20'h7E000, 20'hABCD0);
        wait_strobe();
        check("tmo_issue_ready", 96'(req_ready), 96'h4);
        check("tmo_issue_slot1", 96'(ac97_out_slot1), 96'hFC000);
        req_valid[2] = 1'b0;
        for (int k = 1; k <= RD_TIMEOUT - 1; k++) begin
            wait_strobe();
            check("tmo_wait_rsp", 96'(rsp_valid), 96'h0);
            check("tmo_wait_ready", 96'(req_ready), 96'h0);
        end
        wait_strobe();
        check("tmo_rsp_valid", 96'(rsp_valid), 96'h4);
        check("tmo_rsp_timeout", 96'(rsp_timeout), 96'h1);
        check("tmo_rsp_data", 96'(rsp_data), 96'h0);
        check("tmo_no_grant_same_strobe", 96'(req_ready), 96'h0);
        wait_strobe();
        check("tmo_then_write_ready", 96'(req_ready), 96'h1);
        check("tmo_then_write_slot1", 96'(ac97_out_slot1), 96'h05000);
        check("tmo_then_write_slot2", 96'(ac97_out_slot2), 96'h12340);
        req_valid[0] = 1'b0;
        set_codec(1'b0, 20'h0, 20'h0);

        // Reset in the middle of an outstanding read.
        set_req(0, 1'b1, 1'b1, 7'h30, 16'h0);
        exp_q.push_back(8'd0);
        wait_strobe();
        check("rst_issue_ready", 96'(req_ready), 96'h1);
        req_valid[0] = 1'b0;
        set_codec(1'b1, 20'h30000, 20'h55550);
        wait_strobe();
        repeat (20) @(posedge ac97_bitclk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge ac97_bitclk);
        #1;
        check("rst_mid_read_outputs",
              pack(req_ready, rsp_valid, rsp_data, rsp_timeout,
                   ac97_out_slot1, ac97_out_slot1_valid, ac97_out_slot2, ac97_out_slot2_valid),
              96'd0);
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 7'h01, 16'h1111);
        set_req(1, 1'b1, 1'b0, 7'h02, 16'h2222);
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd1);
        wait_strobe();
        check("rst_prio_first", 96'(req_ready), 96'h1);
        check("rst_no_rsp", 96'(rsp_valid), 96'h0);
        req_valid[0] = 1'b0;
        wait_strobe();
        check("rst_prio_second", 96'(req_ready), 96'h2);
        check("rst_no_rsp_2", 96'(rsp_valid), 96'h0);
        req_valid[1] = 1'b0;
        wait_strobe();
        check("rst_quiet", 96'({rsp_valid, ac97_out_slot1_valid, ac97_out_slot2_valid}), 96'h0);
        set_codec(1'b0, 20'h0, 20'h0);

        @(posedge ac97_bitclk);
        #1;
        check("grant_queue_drained", 96'(exp_q.size()), 96'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
